// File: rtl/mulu_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mulu_operand_loader
//  Description : Operand deserializer in front of the mulu_x3y3 multiplier.
//                Each operand arrives most significant chunk first, one
//                LANE_WIDTH chunk per clock on its own lane. The block
//                assembles full-width x/y and holds them under a
//                valid/ready handshake until the multiplier takes them.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro:
//    MULU_LOADER_OVERRUN_EN - adds the sticky overrun_o flag. It is set when
//                             start_i is seen while a pair is held and not
//                             being transferred in the same cycle.
// ----------------------------------------------------------------------------
//  Parameters:
//    X_WIDTH     width of the assembled x operand
//    Y_WIDTH     width of the assembled y operand
//    LANE_WIDTH  bits per beat on each of the x and y lanes
//  Ports:
//    clk_i        in   1           clock, rising edge
//    reset_i      in   1           asynchronous active-high reset
//    x_lane_i     in   LANE_WIDTH  x chunk of the current beat (MS first)
//    y_lane_i     in   LANE_WIDTH  y chunk of the current beat (MS first)
//    start_i      in   1           first beat of an operand pair
//    out_ready_i  in   1           consumer accepts the held pair
//    x_o          out  X_WIDTH     assembled x (registered)
//    y_o          out  Y_WIDTH     assembled y (registered)
//    out_valid_o  out  1           x_o/y_o hold a complete, unconsumed pair
//    busy_o       out  1           a load is in progress
//    overrun_o    out  1           sticky overrun (MULU_LOADER_OVERRUN_EN)
// ============================================================================
module mulu_operand_loader #(
    parameter int X_WIDTH    = 3,
    parameter int Y_WIDTH    = 3,
    parameter int LANE_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [LANE_WIDTH-1:0] x_lane_i,
    input  logic [LANE_WIDTH-1:0] y_lane_i,
    input  logic                  start_i,
    input  logic                  out_ready_i,
    output logic [X_WIDTH-1:0]    x_o,
    output logic [Y_WIDTH-1:0]    y_o,
    output logic                  out_valid_o,
    output logic                  busy_o
`ifdef MULU_LOADER_OVERRUN_EN
    ,
    output logic                  overrun_o
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int MAX_WIDTH = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int N_BEATS   = (MAX_WIDTH + LANE_WIDTH - 1) / LANE_WIDTH;
    localparam int CNT_WIDTH = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT   = CNT_WIDTH'(N_BEATS - 1);
    localparam logic                 SINGLE_BEAT = (N_BEATS == 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [X_WIDTH-1:0]   xs_q,    xs_d;
    logic [Y_WIDTH-1:0]   ys_q,    ys_d;
    logic [X_WIDTH-1:0]   x_q,     x_d;
    logic [Y_WIDTH-1:0]   y_q,     y_d;
    logic                 valid_q, valid_d;
`ifdef MULU_LOADER_OVERRUN_EN
    logic                 overrun_q, overrun_d;
`endif

    // ------------------------------------------------------------------------
    // Beat assembly helpers
    // ------------------------------------------------------------------------
    // A first beat replaces the shift register; width casts keep only the
    // LSBs, which drops the excess leading bits of an over-wide first chunk.
    logic [X_WIDTH-1:0]            w_x_first;
    logic [Y_WIDTH-1:0]            w_y_first;
    logic [X_WIDTH+LANE_WIDTH-1:0] w_x_cat;
    logic [Y_WIDTH+LANE_WIDTH-1:0] w_y_cat;
    logic [X_WIDTH-1:0]            w_x_shift;
    logic [Y_WIDTH-1:0]            w_y_shift;
    logic                          w_transfer;
    logic                          w_last_beat;

    assign w_x_first   = X_WIDTH'(x_lane_i);
    assign w_y_first   = Y_WIDTH'(y_lane_i);
    assign w_x_cat     = {xs_q, x_lane_i};
    assign w_y_cat     = {ys_q, y_lane_i};
    assign w_x_shift   = w_x_cat[X_WIDTH-1:0];
    assign w_y_shift   = w_y_cat[Y_WIDTH-1:0];
    assign w_transfer  = valid_q & out_ready_i;
    assign w_last_beat = (cnt_q == LAST_BEAT);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = SINGLE_BEAT ? ST_HOLD : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A start here restarts the load, so it never completes it.
                if (!start_i && w_last_beat) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_transfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output and datapath next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        busy_o  = (state_q == ST_SHIFT);
        cnt_d   = cnt_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
`ifdef MULU_LOADER_OVERRUN_EN
        overrun_d = overrun_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    xs_d = w_x_first;
                    ys_d = w_y_first;
                    if (SINGLE_BEAT) begin
                        x_d     = w_x_first;
                        y_d     = w_y_first;
                        valid_d = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (start_i) begin
                    xs_d  = w_x_first;
                    ys_d  = w_y_first;
                    cnt_d = CNT_ONE;
                end else begin
                    xs_d = w_x_shift;
                    ys_d = w_y_shift;
                    if (w_last_beat) begin
                        x_d     = w_x_shift;
                        y_d     = w_y_shift;
                        valid_d = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_HOLD: begin
                if (w_transfer) begin
                    valid_d = 1'b0;
                end
`ifdef MULU_LOADER_OVERRUN_EN
                // A start coinciding with the transfer is harmless: the
                // held pair is leaving anyway.
                if (start_i && !w_transfer) begin
                    overrun_d = 1'b1;
                end
`endif
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= CNT_ZERO;
            xs_q    <= '0;
            ys_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

`ifdef MULU_LOADER_OVERRUN_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`endif

    assign x_o         = x_q;
    assign y_o         = y_q;
    assign out_valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mulu_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mulu_operand_loader
//  Description : Self-checking bench for mulu_operand_loader (default
//                parameters). An arithmetic transaction model is compared
//                against the DUT every cycle; directed literal expectations
//                pin the model for the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mulu_operand_loader;

    localparam int XW    = 3;
    localparam int YW    = 3;
    localparam int LW    = 2;
    localparam int NB    = 2;   // ceil(max(3,3)/2)
    localparam int XMOD  = 8;
    localparam int YMOD  = 8;
    localparam int LMOD  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] x_lane = '0;
    logic [LW-1:0] y_lane = '0;
    logic          start = 1'b0;
    logic          rdy = 1'b0;
    logic [XW-1:0] x_o;
    logic [YW-1:0] y_o;
    logic          valid_o;
    logic          busy_o;
`ifdef MULU_LOADER_OVERRUN_EN
    logic          ovr_o;
`endif

    mulu_operand_loader #(
        .X_WIDTH    (XW),
        .Y_WIDTH    (YW),
        .LANE_WIDTH (LW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .x_lane_i    (x_lane),
        .y_lane_i    (y_lane),
        .start_i     (start),
        .out_ready_i (rdy),
        .x_o         (x_o),
        .y_o         (y_o),
        .out_valid_o (valid_o),
        .busy_o      (busy_o)
`ifdef MULU_LOADER_OVERRUN_EN
        ,
        .overrun_o   (ovr_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction model: phase 0 = waiting, 1 = collecting, 2 = pair held.
    // Operand values are accumulated arithmetically, base 2^LW, mod 2^W.
    // ------------------------------------------------------------------------
    int m_phase, m_beats, m_ax, m_ay, m_x, m_y;
    bit m_ovr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_beats <= 0; m_ax <= 0; m_ay <= 0;
            m_x <= 0; m_y <= 0; m_ovr <= 1'b0;
        end else if (m_phase == 2) begin
            if (rdy) m_phase <= 0;
            else if (start) m_ovr <= 1'b1;
        end else if (start) begin
            // first beat of a pair (also a restart while collecting)
            m_ax <= x_lane % XMOD;
            m_ay <= y_lane % YMOD;
            m_beats <= 1;
            if (NB == 1) begin
                m_x <= x_lane % XMOD; m_y <= y_lane % YMOD; m_phase <= 2;
            end else begin
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_ax <= (m_ax * LMOD + x_lane) % XMOD;
            m_ay <= (m_ay * LMOD + y_lane) % YMOD;
            m_beats <= m_beats + 1;
            if (m_beats + 1 == NB) begin
                m_x <= (m_ax * LMOD + x_lane) % XMOD;
                m_y <= (m_ay * LMOD + y_lane) % YMOD;
                m_phase <= 2;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        chk("model_x", 32'(x_o), 32'(m_x));
        chk("model_y", 32'(y_o), 32'(m_y));
        chk("model_valid", 32'(valid_o), 32'(m_phase == 2));
        chk("model_busy", 32'(busy_o), 32'(m_phase == 1));
`ifdef MULU_LOADER_OVERRUN_EN
        chk("model_overrun", 32'(ovr_o), 32'(m_ovr));
`endif
    end

    // Transfer monitor for the back-to-back scenario.
    int ncyc = 0;
    bit mon_en = 1'b0;
    int q_cyc[$];
    int q_x[$];
    int q_y[$];

    always @(negedge clk) ncyc <= ncyc + 1;

    always @(posedge clk) begin
        if (mon_en && valid_o && rdy) begin
            q_cyc.push_back(ncyc);
            q_x.push_back(int'(x_o));
            q_y.push_back(int'(y_o));
        end
    end

    // One beat: drive inputs, let one rising edge pass, return at negedge.
    task automatic beat(input logic s, input logic [LW-1:0] xl,
                        input logic [LW-1:0] yl, input logic r);
        start  = s;
        x_lane = xl;
        y_lane = yl;
        rdy    = r;
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset state ----------------
        @(negedge clk);
        chk("reset_x", 32'(x_o), 0);
        chk("reset_valid", 32'(valid_o), 0);
        chk("reset_busy", 32'(busy_o), 0);
        rst = 1'b0;
        beat(0, 0, 0, 0);

        // ---------------- basic load: x=5, y=6 ----------------
        beat(1, 2'b01, 2'b01, 1);
        chk("basic_busy", 32'(busy_o), 1);
        chk("basic_valid_early", 32'(valid_o), 0);
        beat(0, 2'b01, 2'b10, 1);
        chk("basic_valid", 32'(valid_o), 1);
        chk("basic_busy_off", 32'(busy_o), 0);
        chk("basic_x", 32'(x_o), 5);
        chk("basic_y", 32'(y_o), 6);
        beat(0, 0, 0, 1);
        chk("basic_valid_drop", 32'(valid_o), 0);
        chk("basic_idle_busy", 32'(busy_o), 0);

        // ---------------- backpressure: x=7, y=2 ----------------
        beat(1, 2'b01, 2'b00, 0);
        beat(0, 2'b11, 2'b10, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(valid_o), 1);
            chk("bp_x", 32'(x_o), 7);
            chk("bp_y", 32'(y_o), 2);
            if (i < 4) beat(0, 0, 0, 0);
        end
        beat(0, 0, 0, 1);
        chk("bp_valid_drop", 32'(valid_o), 0);
        chk("bp_x_kept", 32'(x_o), 7);

        // ---------------- restart in SHIFT: x=3 ----------------
        beat(1, 2'b11, 2'b00, 1);
        chk("rs_busy0", 32'(busy_o), 1);
        beat(1, 2'b00, 2'b00, 1);
        chk("rs_busy1", 32'(busy_o), 1);
        chk("rs_valid_late", 32'(valid_o), 0);
        beat(0, 2'b11, 2'b00, 1);
        chk("rs_valid", 32'(valid_o), 1);
        chk("rs_x", 32'(x_o), 3);
        chk("rs_y", 32'(y_o), 0);
        beat(0, 0, 0, 1);

`ifdef MULU_LOADER_OVERRUN_EN
        // ---------------- overrun: start in HOLD without transfer -------
        beat(1, 2'b01, 2'b01, 0);
        beat(0, 2'b01, 2'b01, 0);
        chk("ovr_pre", 32'(ovr_o), 0);
        beat(1, 2'b11, 2'b11, 0);
        chk("ovr_set", 32'(ovr_o), 1);
        chk("ovr_hold_x", 32'(x_o), 5);
        beat(0, 0, 0, 1);
        chk("ovr_sticky", 32'(ovr_o), 1);
        chk("ovr_valid_drop", 32'(valid_o), 0);
`endif

        // ---------------- asynchronous reset while holding x=7,y=7 -------
        beat(1, 2'b11, 2'b11, 0);
        beat(0, 2'b11, 2'b11, 0);
        chk("ar_pre_x", 32'(x_o), 7);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_x", 32'(x_o), 0);
        chk("ar_y", 32'(y_o), 0);
        chk("ar_valid", 32'(valid_o), 0);
        chk("ar_busy", 32'(busy_o), 0);
`ifdef MULU_LOADER_OVERRUN_EN
        chk("ar_overrun", 32'(ovr_o), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        beat(0, 0, 0, 0);

        // ---------------- start coinciding with transfer is ignored ------
        beat(1, 2'b00, 2'b11, 0);
        beat(0, 2'b10, 2'b01, 0);
        chk("st_x", 32'(x_o), 2);
        chk("st_y", 32'(y_o), 5);
        beat(1, 2'b11, 2'b11, 1);
        chk("st_valid", 32'(valid_o), 0);
        chk("st_busy", 32'(busy_o), 0);
`ifdef MULU_LOADER_OVERRUN_EN
        chk("st_overrun", 32'(ovr_o), 0);
`endif
        beat(0, 0, 0, 1);
        chk("st_idle_busy", 32'(busy_o), 0);

        // ---------------- back-to-back: (1,4) then (6,3) ----------------
        mon_en = 1'b1;
        beat(1, 2'b00, 2'b01, 1);
        beat(0, 2'b01, 2'b00, 1);
        beat(0, 0, 0, 1);
        beat(1, 2'b01, 2'b00, 1);
        beat(0, 2'b10, 2'b11, 1);
        beat(0, 0, 0, 1);
        beat(0, 0, 0, 1);
        mon_en = 1'b0;
        chk("b2b_count", 32'(q_cyc.size()), 2);
        if (q_cyc.size() == 2) begin
            chk("b2b_x0", 32'(q_x[0]), 1);
            chk("b2b_y0", 32'(q_y[0]), 4);
            chk("b2b_x1", 32'(q_x[1]), 6);
            chk("b2b_y1", 32'(q_y[1]), 3);
            chk("b2b_spacing", 32'(q_cyc[1] - q_cyc[0]), 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mulu_operand_loader.md
# mulu_operand_loader

Operand deserializer that sits directly upstream of the `mulu_x3y3` multiplier. The top level has only a few input pins, so each operand arrives in narrow lanes over several clocks. This block assembles full-width `x`/`y` from those lanes and presents them to the multiplier's `x`/`y` inputs, holding them stable under a valid/ready handshake. The multiplier's `rdy` (under `HAS_READY`) or a tie-high drives `out_ready`.

## Interface
- `X_WIDTH`, default 3: width of the assembled x operand.
- `Y_WIDTH`, default 3: width of the assembled y operand.
- `LANE_WIDTH`, default 2: bits per beat on each of the x and y lanes.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `x_lane`  in  LANE_WIDTH  x chunk for the current beat, most significant chunk first.
- `y_lane`  in  LANE_WIDTH  y chunk for the current beat, most significant chunk first.
- `start`  in  1  marks the first beat of an operand pair.
- `out_ready`  in  1  consumer accepts the held operands.
- `x`  out  X_WIDTH  assembled x, registered.
- `y`  out  Y_WIDTH  assembled y, registered.
- `out_valid`  out  1  `x`/`y` hold a complete, unconsumed pair.
- `busy`  out  1  a load is in progress (SHIFT state).
- `overrun`  out  1  present only with `MULU_LOADER_OVERRUN_EN`.

## Operation
- Beat count: N = ceil(max(X_WIDTH, Y_WIDTH) / LANE_WIDTH). With the defaults, N = 2.
- Internal shift registers `xs` and `ys` update each beat:
  - `xs <= {xs, x_lane}` truncated to X_WIDTH LSBs; `ys` is handled the same way.
  - Excess leading bits of the first chunk are discarded.
- A beat counter runs from 0 to N-1.
- FSM states are IDLE, SHIFT and HOLD.
- **IDLE:**
  - On `start=1`, capture beat 0 into `xs`/`ys` with the counter set to 1.
  - Go to SHIFT, or go straight to HOLD if N = 1.
- **SHIFT:**
  - Every cycle captures one beat; `start` is not required.
  - `start=1` in SHIFT restarts the load: that cycle's lanes become beat 0 and the counter is set to 1.
  - On the capture of beat N-1, copy the assembled values into the output registers `x`/`y`, set `out_valid`, and go to HOLD.
- **HOLD:**
  - `x`, `y` and `out_valid=1` are stable.
  - When `out_valid && out_ready`, clear `out_valid` and go to IDLE.
  - `start` in HOLD is ignored and no lanes are captured.
- `x`/`y` change only on load completion. They keep their last value after a transfer.
- `busy` = (state == SHIFT).

## Timing
- Reset values: `x=0`, `y=0`, `out_valid=0`, `busy=0`, `overrun=0`, state IDLE, counter 0, `xs`/`ys` = 0.
- Reset is asynchronous, so outputs clear immediately, including mid-load and in HOLD. The partial load is discarded.
- Latency: with `start` sampled at edge 0, beats are sampled at edges 0..N-1, and `out_valid` rises after edge N-1. With the defaults, `out_valid` is high in the cycle after edge 1.
- With `out_ready` held high, `out_valid` is high for exactly 1 cycle. The next `start` is accepted at the following edge (IDLE).
- Peak throughput is one pair per N+1 cycles.
- A `start` in the same cycle as the transfer is ignored. It does not set `overrun`.
- `out_ready` is don't-care outside HOLD.

## Configuration
- `MULU_LOADER_OVERRUN_EN` defined:
  - Adds the `overrun` output.
  - `overrun` is a sticky flag, set at the edge where `start=1` is sampled in HOLD without a transfer in the same cycle.
  - It is cleared only by `reset`.
- `MULU_LOADER_OVERRUN_EN` undefined:
  - No `overrun` port and no flag logic.
  - `start` in HOLD is silently ignored.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle -> `x=0`, `y=0`, `out_valid=0` and `busy=0` immediately, before the next edge.
- **Basic load** (defaults, `out_ready=1`):
  - Stimulus: `start=1` with lanes x=01, y=01, then lanes x=01, y=10.
  - Required: `busy=1` for 1 cycle, then `out_valid=1` for 1 cycle with `x=5`, `y=6`, then back in IDLE.
- **Backpressure:** load x=7 (lanes 01, 11), y=2 (lanes 00, 10) with `out_ready=0` -> `out_valid`, `x=7` and `y=2` hold for 5 cycles. Raise `out_ready` -> `out_valid` clears the next cycle.
- **Restart in SHIFT:**
  - Stimulus: `start` with x-lane 11, then `start` again with x-lane 00, then x-lane 11.
  - Required: `x=3`, and `out_valid` rises 1 cycle later than for an uninterrupted load.
- **Overrun** (with `MULU_LOADER_OVERRUN_EN`):
  - Pulse `start` in HOLD with `out_ready=0` -> `overrun=1`, and it stays set after the transfer.
  - Repeat with `out_ready=1` in the same cycle -> `overrun` stays 0.
- **Back-to-back:**
  - Stimulus: two loads, (x=1, y=4) then (x=6, y=3), with `start` issued the first cycle after each transfer.
  - Required: both pairs are seen exactly once, 3 cycles apart.
